// File: rtl/writeback_arbiter_pkg.sv
// Shared processor definitions for the writeback path.
// Provides the default data width, the register-index width and type, the
// holding-entry record, and a small helper for register-match comparisons.
package writeback_arbiter_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // One holding-register entry at the default data width.
  typedef struct packed {
    logic                valid;
    reg_idx_t            rd;
    logic [XLEN_DEF-1:0] data;
  } wb_entry_t;

  // True when a live entry targets the queried register.
  function automatic logic reg_match(input reg_idx_t query, input logic live, input reg_idx_t rd);
    return live && (rd == query);
  endfunction

endpackage

// File: rtl/wb_hold_slot.sv
// One-entry holding register for a writeback channel.
// Ports:
//   clk, reset          clock and asynchronous active-low reset
//   in_valid/in_rd/
//   in_data             result offered by the producer
//   ready               accept strobe back to the producer
//   grant               arbiter takes this entry at the next edge
//   full/hold_rd/
//   hold_data           current entry contents
module wb_hold_slot
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  reg_idx_t        in_rd,
  input  logic [XLEN-1:0] in_data,
  input  logic            grant,
  output logic            ready,
  output logic            full,
  output reg_idx_t        hold_rd,
  output logic [XLEN-1:0] hold_data
);

  logic            full_q, full_d;
  reg_idx_t        rd_q;
  logic [XLEN-1:0] data_q;
  logic            load;

  always_comb begin
    // Ready never looks at in_valid, so producers may wait on it freely.
    ready  = !full_q || grant;
    // Writes to x0 are accepted but never stored.
    load   = in_valid && ready && (in_rd != '0);
    full_d = load || (full_q && !grant);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      if (load) begin
        rd_q   <= in_rd;
        data_q <= in_data;
      end
    end
  end

  assign full      = full_q;
  assign hold_rd   = rd_q;
  assign hold_data = data_q;

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file writeback arbiter between an ALU channel and a load channel.
// Ports:
//   clk, reset                      clock and asynchronous active-low reset
//   alu_valid/alu_rd/alu_data/
//   alu_ready                       ALU result channel
//   mem_valid/mem_rd/mem_data/
//   mem_ready                       load result channel
//   rd/write_data/reg_write         registered register-file write port
//   query_rs1/query_rs2             decode source registers
//   pending1/pending2               queried register has an uncommitted write
// Loads win arbitration, but an ALU result is forced through after
// STARVE_LIMIT consecutive load grants.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned XLEN         = XLEN_DEF,
  parameter int unsigned STARVE_LIMIT = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  input  reg_idx_t        alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  reg_idx_t        mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  output reg_idx_t        rd,
  output logic [XLEN-1:0] write_data,
  output logic            reg_write,
  input  reg_idx_t        query_rs1,
  input  reg_idx_t        query_rs2,
  output logic            pending1,
  output logic            pending2
);

  localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

  logic            alu_full, mem_full;
  reg_idx_t        alu_hold_rd, mem_hold_rd;
  logic [XLEN-1:0] alu_hold_data, mem_hold_data;
  logic            alu_prio, grant_alu, grant_mem;
  logic [CntW-1:0] starve_q, starve_d;
  reg_idx_t        rd_q;
  logic [XLEN-1:0] data_q;
  logic            we_q;

  wb_hold_slot #(.XLEN(XLEN)) u_alu_slot (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (alu_valid),
    .in_rd     (alu_rd),
    .in_data   (alu_data),
    .grant     (grant_alu),
    .ready     (alu_ready),
    .full      (alu_full),
    .hold_rd   (alu_hold_rd),
    .hold_data (alu_hold_data)
  );

  wb_hold_slot #(.XLEN(XLEN)) u_mem_slot (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (mem_valid),
    .in_rd     (mem_rd),
    .in_data   (mem_data),
    .grant     (grant_mem),
    .ready     (mem_ready),
    .full      (mem_full),
    .hold_rd   (mem_hold_rd),
    .hold_data (mem_hold_data)
  );

  always_comb begin
    alu_prio  = alu_full && (starve_q == Limit);
    grant_alu = alu_full && (!mem_full || alu_prio);
    grant_mem = mem_full && !alu_prio;

    // Count only load grants that overtake a waiting ALU result.
    starve_d = starve_q;
    if (!alu_full || grant_alu) begin
      starve_d = '0;
    end else if (grant_mem && (starve_q != Limit)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q <= '0;
      rd_q     <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
    end else begin
      starve_q <= starve_d;
      we_q     <= grant_alu || grant_mem;
      if (grant_mem) begin
        rd_q   <= mem_hold_rd;
        data_q <= mem_hold_data;
      end else if (grant_alu) begin
        rd_q   <= alu_hold_rd;
        data_q <= alu_hold_data;
      end
    end
  end

  assign rd         = rd_q;
  assign write_data = data_q;
  assign reg_write  = we_q;

  // x0 never reports a hazard; otherwise any held or in-flight write counts.
  always_comb begin
    pending1 = (query_rs1 != '0) && (reg_match(query_rs1, alu_full, alu_hold_rd) ||
                                     reg_match(query_rs1, mem_full, mem_hold_rd) ||
                                     reg_match(query_rs1, we_q, rd_q));
    pending2 = (query_rs2 != '0) && (reg_match(query_rs2, alu_full, alu_hold_rd) ||
                                     reg_match(query_rs2, mem_full, mem_hold_rd) ||
                                     reg_match(query_rs2, we_q, rd_q));
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid;
  logic [4:0]  alu_rd, mem_rd, query_rs1, query_rs2;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready;
  logic [4:0]  rd;
  logic [31:0] write_data;
  logic        reg_write, pending1, pending2;

  int n_tests = 0;
  int n_fail  = 0;

  writeback_arbiter #(.XLEN(32), .STARVE_LIMIT(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .alu_ready  (alu_ready),
    .mem_valid  (mem_valid),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .rd         (rd),
    .write_data (write_data),
    .reg_write  (reg_write),
    .query_rs1  (query_rs1),
    .query_rs2  (query_rs2),
    .pending1   (pending1),
    .pending2   (pending2)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_write(input string tag, input logic [4:0] exp_rd, input logic [31:0] exp_d);
    check_eq({tag, ".we"}, 64'(reg_write), 64'(1'b1));
    check_eq({tag, ".rd"}, 64'(rd), 64'(exp_rd));
    check_eq({tag, ".wd"}, 64'(write_data), 64'(exp_d));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    query_rs1 = 5'd5; query_rs2 = 5'd9;
    step(); step();

    // Reset state
    check_eq("rst.we", 64'(reg_write), 64'd0);
    check_eq("rst.rd", 64'(rd), 64'd0);
    check_eq("rst.wd", 64'(write_data), 64'd0);
    check_eq("rst.p1", 64'(pending1), 64'd0);
    check_eq("rst.p2", 64'(pending2), 64'd0);
    check_eq("rst.alu_ready", 64'(alu_ready), 64'd1);
    check_eq("rst.mem_ready", 64'(mem_ready), 64'd1);
    #2 reset = 1'b1;
    step();

    // Single ALU result
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hABCD1234;
    check_eq("single.ready", 64'(alu_ready), 64'd1);
    step();
    alu_valid = 1'b0;
    check_eq("single.p1_held", 64'(pending1), 64'd1);
    check_eq("single.we_early", 64'(reg_write), 64'd0);
    step();
    check_write("single", 5'd5, 32'hABCD1234);
    check_eq("single.p1_wr", 64'(pending1), 64'd1);
    step();
    check_eq("single.we_drop", 64'(reg_write), 64'd0);
    check_eq("single.rd_hold", 64'(rd), 64'd5);
    check_eq("single.p1_done", 64'(pending1), 64'd0);

    // Simultaneous: load first, ALU one cycle later
    alu_valid = 1'b1; alu_rd = 5'd9;  alu_data = 32'h12345678;
    mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'h98765432;
    check_eq("simul.alu_ready", 64'(alu_ready), 64'd1);
    check_eq("simul.mem_ready", 64'(mem_ready), 64'd1);
    step();
    alu_valid = 1'b0; mem_valid = 1'b0;
    check_eq("simul.p2_held", 64'(pending2), 64'd1);
    step();
    check_write("simul.mem", 5'd10, 32'h98765432);
    step();
    check_write("simul.alu", 5'd9, 32'h12345678);
    step();
    check_eq("simul.we_drop", 64'(reg_write), 64'd0);

    // Write to x0 is swallowed
    query_rs1 = 5'd0;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
    check_eq("x0.ready", 64'(alu_ready), 64'd1);
    step();
    alu_valid = 1'b0;
    check_eq("x0.p1", 64'(pending1), 64'd0);
    check_eq("x0.ready_after", 64'(alu_ready), 64'd1);
    step();
    check_eq("x0.we1", 64'(reg_write), 64'd0);
    step();
    check_eq("x0.we2", 64'(reg_write), 64'd0);

    // Streaming on one channel
    alu_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      alu_rd = 5'(i); alu_data = 32'h100 + 32'(i);
      step();
      if (i > 1) check_write("stream", 5'(i - 1), 32'h100 + 32'(i - 1));
    end
    alu_valid = 1'b0;
    step();
    check_write("stream.last", 5'd3, 32'h103);
    step();
    check_eq("stream.we_drop", 64'(reg_write), 64'd0);

    // Starvation: ALU forced through after two load grants
    alu_valid = 1'b1; alu_rd = 5'd15; alu_data = 32'hDEADBEEF;
    mem_valid = 1'b1; mem_rd = 5'd20; mem_data = 32'h55;
    step();
    alu_valid = 1'b0;
    step();
    check_write("starve.g1", 5'd20, 32'h55);
    check_eq("starve.alu_wait", 64'(alu_ready), 64'd0);
    step();
    check_write("starve.g2", 5'd20, 32'h55);
    check_eq("starve.mem_blocked", 64'(mem_ready), 64'd0);
    step();
    check_write("starve.alu", 5'd15, 32'hDEADBEEF);
    step();
    check_write("starve.g3", 5'd20, 32'h55);
    step();
    mem_valid = 1'b0;
    step();
    check_write("starve.g5", 5'd20, 32'h55);
    step();
    check_eq("starve.we_drop", 64'(reg_write), 64'd0);
    check_eq("starve.alu_ready", 64'(alu_ready), 64'd1);
    check_eq("starve.mem_ready", 64'(mem_ready), 64'd1);

    // Hazard query on a held load
    query_rs1 = 5'd8; query_rs2 = 5'd16;
    mem_valid = 1'b1; mem_rd = 5'd8; mem_data = 32'h88;
    check_eq("haz.p1_before", 64'(pending1), 64'd0);
    step();
    mem_valid = 1'b0;
    check_eq("haz.p1_held", 64'(pending1), 64'd1);
    check_eq("haz.p2_held", 64'(pending2), 64'd0);
    step();
    check_write("haz", 5'd8, 32'h88);
    check_eq("haz.p1_wr", 64'(pending1), 64'd1);
    step();
    check_eq("haz.p1_done", 64'(pending1), 64'd0);

    // Reset mid-flight
    query_rs1 = 5'd3; query_rs2 = 5'd4;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h44;
    step();
    alu_valid = 1'b0; mem_valid = 1'b0;
    check_eq("rmid.p1_full", 64'(pending1), 64'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("rmid.we", 64'(reg_write), 64'd0);
    check_eq("rmid.rd", 64'(rd), 64'd0);
    check_eq("rmid.p1", 64'(pending1), 64'd0);
    check_eq("rmid.p2", 64'(pending2), 64'd0);
    check_eq("rmid.alu_ready", 64'(alu_ready), 64'd1);
    step();
    check_eq("rmid.we_held", 64'(reg_write), 64'd0);
    #2 reset = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    check_eq("rmid.ready_post", 64'(alu_ready), 64'd1);
    step();
    alu_valid = 1'b0;
    check_eq("rmid.no_stale", 64'(reg_write), 64'd0);
    step();
    check_write("rmid.new", 5'd7, 32'h77);
    step();
    check_eq("rmid.we_drop", 64'(reg_write), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter XLEN, default 32, data width of every result and write-data path.
REQ-002 Parameter STARVE_LIMIT, default 2, maximum consecutive load grants while an ALU result waits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; the port name is "reset", and the polarity and asynchronous behaviour are fixed.
REQ-005 alu_valid  input  1  ALU result offered.
REQ-006 alu_rd  input  5  ALU destination register.
REQ-007 alu_data  input  XLEN  ALU result.
REQ-008 alu_ready  output  1  ALU result accepted when alu_valid and alu_ready are both high.
REQ-009 mem_valid / mem_rd / mem_data / mem_ready  in/in/in/out  1/5/XLEN/1  load-result channel, same rules as the ALU channel.
REQ-010 rd  output  5  register-file write address.
REQ-011 write_data  output  XLEN  register-file write data.
REQ-012 reg_write  output  1  register-file write enable, one cycle per committed write.
REQ-013 query_rs1 / query_rs2  input  5  source registers from decode.
REQ-014 pending1 / pending2  output  1  the queried register has an uncommitted write in this block.

Function
REQ-015 Each channel SHALL own one holding register (valid, rd, data).
REQ-016 ready SHALL equal (holding register empty) OR (holding register granted this cycle); it is combinational, with no dependence on the same channel's valid.
REQ-017 An accepted result with rd == 0 SHALL be consumed and discarded: it is never loaded and never produces reg_write.
REQ-018 Each cycle the arbiter SHALL grant at most one full holding register; that register's contents load the output registers (rd, write_data, reg_write=1) at the same edge, and the holding register frees.
REQ-019 Priority SHALL be load over ALU, except when starve_cnt == STARVE_LIMIT with the ALU holding register full; then the ALU SHALL be granted.
REQ-020 starve_cnt SHALL increment on a load grant while the ALU holding register is full, clear on any ALU grant or whenever the ALU holding register is empty, and saturate at STARVE_LIMIT.
REQ-021 Latency SHALL be as follows: a result accepted at edge T and granted at edge T+1 drives reg_write high during cycle T+1..T+2, so it is written in the register file at edge T+2.
REQ-022 reg_write SHALL drop to 0 in any cycle following an edge with no grant; rd and write_data SHALL hold their previous values.
REQ-023 Full throughput SHALL hold: with one holding register full and an accept on the same channel at the grant edge, the channel streams one result per cycle.
REQ-024 Simultaneous results on both channels SHALL both be accepted when both holding registers are empty or granted; the non-granted result waits.
REQ-025 Both holding registers targeting the same rd SHALL be committed in grant order; no merging is performed.
REQ-026 pendingN SHALL be 1 iff query_rsN != 0 and query_rsN matches a full holding register's rd or (reg_write and rd); the logic is combinational.

Reset
REQ-027 While reset is low the block SHALL hold: holding registers empty, starve_cnt 0, reg_write 0, rd 0, write_data 0, pending1/pending2 0, alu_ready/mem_ready 1.
REQ-028 Reset asserted mid-operation SHALL discard all held results without any reg_write pulse; the first accept is possible in the first cycle after deassertion.

Structure
REQ-029 XLEN default, register-index width (5) and a holding-entry record typedef (valid, rd, data) SHALL live in the shared processor package.
REQ-030 One sub-module, wb_hold_slot (holding register plus ready logic), SHALL be instantiated once per channel; arbitration, starve counter and output registers stay in the top.

Verification
REQ-031 Single ALU: alu rd=5, data=0xABCD1234 accepted at edge T -> reg_write=1, rd=5, write_data=0xABCD1234 in cycle after T+1; reg_write=0 the next cycle.
REQ-032 Simultaneous: alu rd=9 0x12345678 and mem rd=10 0x98765432 at the same edge -> mem committed first, alu one cycle later, both ready high throughout.
REQ-033 rd=0 drop: alu rd=0, data=0xFFFFFFFF -> accepted, no reg_write pulse; pending for query 0 stays 0.
REQ-034 Starvation: mem_valid held high for 6 cycles with alu rd=15 0xDEADBEEF waiting -> alu committed after exactly 2 load grants.
REQ-035 Hazard: mem rd=8 held; query_rs1=8, query_rs2=16 -> pending1=1, pending2=0 until rd=8 reg_write cycle ends.
REQ-036 Reset mid-flight: both holding registers full, reset pulsed low -> no reg_write, all outputs at reset values, new accept succeeds in the cycle after release.
